// File: rtl/mem_pkg.sv
// Shared definitions for mem and its bulk loader: loader FSM states and data/IO segment layout.
// No logic of its own; the I/O start address helper is shared with mem.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    NEXT,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned DATA_SEG_COUNT = 6;
  localparam int unsigned IO_START_SEG   = 7;

  // Address mem decodes as the program-visible startIO flag.
  function automatic int unsigned io_start_addr(input int unsigned ramsize);
    return ramsize * IO_START_SEG;
  endfunction

endpackage

// File: rtl/mem_loader_byte_assembler.sv
// Packs a little-endian byte stream into WIDTH-bit words; word is combinational and includes the byte being accepted.
// Latency: a word is complete on the edge that accepts its last byte. No backpressure: the parent gates accept.
module byte_assembler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             clear,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] word,
  output logic             last_byte
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]    byte_cnt;
  logic [WIDTH-1:0] lanes;

  // Merge the incoming byte so the parent can capture a full word on the last accept.
  always_comb begin
    word = lanes;
    for (int k = 0; k < NB; k++) begin
      if (accept && (byte_cnt == CW'(k))) begin
        word[8*k +: 8] = data;
      end
    end
  end

  assign last_byte = (byte_cnt == CW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (accept) begin
      lanes    <= word;
      byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Bulk loader for mem's data segments: bytes -> words -> we/a2/wd writes, startIO on completion; MEM_LOADER_VERIFY_EN adds read-back.
// Latency: WIDTH/8 + 2 cycles per word (+1 with verify). Backpressure: in_ready only in RECV; in_valid low stalls indefinitely.
module mem_loader
  import mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RAMSIZE = 1024,
  parameter int NSEG    = DATA_SEG_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [WIDTH-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             we,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] rd2,
  output logic             startIO,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(RAMSIZE * NSEG);

  loader_state_t    state, state_nxt;
  logic [WIDTH-1:0] addr, remaining;
  logic [WIDTH-1:0] a2_q, wd_q;
  logic             done_q, enter_done;
  logic [WIDTH:0]   range_sum;
  logic             start_acc, accept, last_byte;
  logic [WIDTH-1:0] asm_word;

  assign busy      = (state == RECV) || (state == WRITE) || (state == CHECK) || (state == NEXT);
  assign start_acc = start && !busy;
  assign accept    = (state == RECV) && in_valid;
  // One extra bit so a range that runs past the top of the address space cannot wrap into range.
  assign range_sum = {1'b0, base_addr} + {1'b0, word_count};

`ifndef MEM_LOADER_VERIFY_EN
  logic unused_rd2;
  assign unused_rd2 = ^rd2;
`endif

  byte_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .clear     (start_acc),
    .data      (in_data),
    .word      (asm_word),
    .last_byte (last_byte)
  );

  always_comb begin
    state_nxt  = state;
    enter_done = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (range_sum > LIMIT) begin
            state_nxt = ERROR;
          end else if (word_count == '0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        if (accept && last_byte) state_nxt = WRITE;
      end
      WRITE: begin
`ifdef MEM_LOADER_VERIFY_EN
        state_nxt = CHECK;
`else
        state_nxt = NEXT;
`endif
      end
`ifdef MEM_LOADER_VERIFY_EN
      CHECK: begin
        state_nxt = (rd2 == wd_q) ? NEXT : ERROR;
      end
`endif
      NEXT: begin
        if (remaining == WIDTH'(1)) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          state_nxt = RECV;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      a2_q      <= '0;
      wd_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= enter_done;
      if (start_acc) begin
        addr      <= base_addr;
        remaining <= word_count;
      end
      if (state == NEXT) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      // a2/wd only move when a write is launched, so they hold through CHECK and idle periods.
      if (state_nxt == WRITE) begin
        a2_q <= addr;
        wd_q <= asm_word;
      end
    end
  end

  assign in_ready = (state == RECV);
  assign we       = (state == WRITE);
  assign a2       = a2_q;
  assign wd       = wd_q;
  assign startIO  = (state == DONE);
  assign done     = done_q;
  assign error    = (state == ERROR);

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued at stimulus time and checked by a write monitor.
// A behavioural mem array receives the writes and drives rd2.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, we, startIO, busy, done, error;
  logic [31:0] base_addr, word_count, a2, wd, rd2;
  logic [7:0]  in_data;
  logic        force_bad;

  logic [31:0] mem_m [0:8191];
  logic [63:0] exp_q [$];
  logic [63:0] e;
  int n_pass = 0, n_total = 0;
  int we_cnt = 0, done_cnt = 0;
  int w0, d0;

  always #5 clk = ~clk;

  mem_loader #(.WIDTH(32), .RAMSIZE(1024), .NSEG(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .we         (we),
    .a2         (a2),
    .wd         (wd),
    .rd2        (rd2),
    .startIO    (startIO),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  assign rd2 = force_bad ? 32'hDEADBEEF : mem_m[a2[12:0]];
  always @(posedge clk) if (we) mem_m[a2[12:0]] <= wd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  // Write monitor: every we cycle must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (we) begin
        we_cnt++;
        check("wr_in_ready_low", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL wr_unexpected: actual a2=%0h wd=%0h expected no write", a2, wd);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr_data", {a2, wd}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: actual in_ready=0 expected 1 within 100 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n, input bit tog);
    for (int i = 0; i < n; i++) begin
      send_byte(v[8*i +: 8]);
      if (tog) tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outs(input string name);
    check(name, {58'd0, in_ready, we, startIO, busy, done, error}, 64'd0);
    check({name, "_a2wd"}, {a2, wd}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    base_addr = '0; word_count = '0; force_bad = 1'b0;
    tick(); tick();
    check_reset_outs("reset");
    rst = 1'b0;
    tick();

    // Simple load with cycle-exact handshake timing.
    d0 = done_cnt;
    exp_q.push_back({32'd0, 32'h44332211});
    exp_q.push_back({32'd1, 32'h88776655});
    do_start(32'd0, 32'd2);
    check("start_in_ready_e1", 64'(in_ready), 64'd1);
    check("start_busy", 64'(busy), 64'd1);
    send_bytes(64'h44332211, 4, 1'b0);
    check("we_cycle_n1", 64'(we), 64'd1);
    tick();
    check("gap_in_ready_n2", 64'(in_ready), 64'd0);
`ifdef MEM_LOADER_VERIFY_EN
    tick();
    check("gap_in_ready_n3", 64'(in_ready), 64'd0);
`endif
    tick();
    check("rearm_in_ready", 64'(in_ready), 64'd1);
    send_bytes(64'h88776655, 4, 1'b0);
    wait_idle("simple_idle");
    check("simple_startio", 64'(startIO), 64'd1);
    tick();
    tick();
    check("simple_done_once", 64'(done_cnt - d0), 64'd1);
    check("simple_done_pulse", {62'd0, done, error}, 64'd0);
    check("simple_startio_held", 64'(startIO), 64'd1);

    // Segment crossing.
    exp_q.push_back({32'd1023, 32'h04030201});
    exp_q.push_back({32'd1024, 32'h08070605});
    do_start(32'd1023, 32'd2);
    check("seg_startio_cleared", 64'(startIO), 64'd0);
    send_bytes(64'h0807060504030201, 8, 1'b0);
    wait_idle("seg_idle");
    tick();
    check("seg_mem_1023", 64'(mem_m[1023]), 64'h04030201);
    check("seg_mem_1024", 64'(mem_m[1024]), 64'h08070605);

    // Range error one word past the end, then the exact-fit range clears it.
    w0 = we_cnt;
    do_start(32'd6143, 32'd2);
    check("range_err_flags", {61'd0, error, startIO, busy}, 64'b100);
    tick(); tick(); tick();
    check("range_no_we", 64'(we_cnt - w0), 64'd0);
    check("range_err_sticky", 64'(error), 64'd1);
    exp_q.push_back({32'd6142, 32'h12345678});
    exp_q.push_back({32'd6143, 32'h9ABCDEF0});
    do_start(32'd6142, 32'd2);
    check("err_cleared", {62'd0, error, busy}, 64'b01);
    send_bytes(64'h9ABCDEF012345678, 8, 1'b0);
    wait_idle("edge_idle");
    check("edge_startio", 64'(startIO), 64'd1);

    // Zero count.
    tick();
    w0 = we_cnt; d0 = done_cnt;
    do_start(32'd5, 32'd0);
    check("zero_done_e1", {62'd0, done, startIO}, 64'b11);
    tick(); tick();
    check("zero_done_once", 64'(done_cnt - d0), 64'd1);
    check("zero_no_we", 64'(we_cnt - w0), 64'd0);

    // Reset after two bytes of a word; the next load writes only its own word.
    do_start(32'd10, 32'd1);
    send_bytes(64'hBBAA, 2, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outs("mid_reset");
    rst = 1'b0;
    tick();
    w0 = we_cnt;
    exp_q.push_back({32'd20, 32'hD4C3B2A1});
    do_start(32'd20, 32'd1);
    send_bytes(64'hD4C3B2A1, 4, 1'b0);
    wait_idle("mid_idle");
    tick();
    check("mid_one_write", 64'(we_cnt - w0), 64'd1);

    // in_valid toggling every cycle.
    exp_q.push_back({32'd0, 32'h44332211});
    exp_q.push_back({32'd1, 32'h88776655});
    do_start(32'd0, 32'd2);
    send_bytes(64'h8877665544332211, 8, 1'b1);
    wait_idle("stall_idle");
    check("stall_startio", 64'(startIO), 64'd1);

`ifdef MEM_LOADER_VERIFY_EN
    // Read-back mismatch aborts after the first word.
    tick();
    force_bad = 1'b1;
    exp_q.push_back({32'd100, 32'h11223344});
    do_start(32'd100, 32'd2);
    send_bytes(64'h11223344, 4, 1'b0);
    for (int i = 0; i < 20 && !error; i++) tick();
    check("verify_err", {61'd0, error, startIO, busy}, 64'b100);
    force_bad = 1'b0;
`endif

    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Bulk-load initiator for the data segment of `mem`. It accepts a byte stream over a valid/ready handshake and assembles it into WIDTH-bit words. Each word is written to consecutive data-segment addresses through `mem`'s `we`/`a2`/`wd` port. When the transfer completes, it raises `startIO`, which `mem` exposes to the program at I/O address RAMSIZE*7. It sits between the host/UART byte source and `mem`, and owns the data port only while `busy` is high.

## Interface
- WIDTH, 32, data word width; multiple of 8.
- RAMSIZE, 1024, words per data segment; must match `mem`.
- NSEG, 6, number of data segments; writable range is 0 .. RAMSIZE*NSEG-1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  pulse; begins a load. Ignored while `busy`.
- base_addr  in  WIDTH  first word address. Sampled on the accepted `start`.
- word_count  in  WIDTH  number of words to load. Sampled on the accepted `start`.
- in_valid  in  1  byte available.
- in_data  in  8  byte, little-endian within a word.
- in_ready  out  1  byte accepted when `in_valid && in_ready`.
- we  out  1  write enable to `mem`.
- a2  out  WIDTH  data address to `mem`.
- wd  out  WIDTH  write data to `mem`.
- rd2  in  WIDTH  read data from `mem`; used only with MEM_LOADER_VERIFY_EN.
- startIO  out  1  load-complete flag, wired to `mem`.startIO.
- busy  out  1  high from the accepted `start` until DONE or ERROR is entered.
- done  out  1  one-cycle pulse on entering DONE.
- error  out  1  sticky, held in ERROR.

## Operation
- Reset values: in_ready=0, we=0, a2=0, wd=0, startIO=0, busy=0, done=0, error=0. FSM state is IDLE and the byte counter is 0.
- States and transitions:
  - IDLE: on `start`, latch base_addr and word_count, then check the range.
  - Range check: if base_addr+word_count > RAMSIZE*NSEG, compute the sum WIDTH+1 bits wide with no wrap, go to ERROR, and perform no writes.
  - word_count==0: go directly to DONE.
  - Otherwise go to RECV.
- RECV: in_ready=1. Each accepted byte goes into lane byte_cnt (bits 8*k+7:8*k). byte_cnt wraps at WIDTH/8. On the last byte, go to WRITE.
- WRITE: exactly one cycle with we=1, a2=addr, wd=assembled word, in_ready=0.
  - Then go to CHECK if MEM_LOADER_VERIFY_EN is defined, otherwise to NEXT.
- NEXT: addr+=1 and remaining-=1. If remaining reaches 0, go to DONE, otherwise go to RECV.
- DONE: startIO=1, held until `rst` or a new accepted `start`. A new start clears startIO in the same edge it is accepted.
- ERROR: error=1, startIO=0. Leave only on `rst` or `start`; `start` clears `error` and restarts.
- `a2` holds its last value outside WRITE/CHECK. `we` is never high outside WRITE.
- Reset mid-transfer: all outputs take their reset values at the next edge. A partial word is discarded and previously written words stay in memory.
- A write to I/O address RAMSIZE*7 is impossible by construction, because of the range check.

## Timing
- `start` accepted at edge E; in_ready=1 from cycle E+1.
- Last byte of a word accepted at edge N: we=1 in cycle N+1.
  - Without the macro: in_ready=1 again in cycle N+3 (WRITE, then NEXT).
  - With the macro: in_ready=1 again in cycle N+4 (WRITE, CHECK, NEXT).
- Throughput: WIDTH/8 + 2 cycles per word (+1 with verify), assuming in_valid is held high.
- `done` and `startIO` rise in the cycle after the final NEXT.
- in_valid low simply stalls RECV. There is no timeout.

## Configuration
- MEM_LOADER_VERIFY_EN defined: CHECK state is compiled in.
  - In the cycle after WRITE, a2 is held and rd2 is compared with wd.
  - On a match, go to NEXT.
  - On a mismatch, go to ERROR with startIO kept 0.
- Not defined: the rd2 port is present but ignored, and the CHECK state does not exist.

## Structure
- Shared package `mem_pkg`:
  - `loader_state_t` enum: IDLE, RECV, WRITE, CHECK, NEXT, DONE, ERROR.
  - Constants DATA_SEG_COUNT=6 and IO_START_SEG=7.
  - Function `io_start_addr(ramsize)` returning ramsize*IO_START_SEG; shared with `mem`.
- One sub-module, `byte_assembler`:
  - Holds the byte counter and lane shift register.
  - Inputs: byte-accept strobe and clear.
  - Outputs: `word` and a `last_byte` flag.

## Test plan
- Simple load: base=0, count=2, bytes 11 22 33 44 55 66 77 88 with in_valid=1 -> writes 0x44332211@0 and 0x88776655@1; done pulses once; startIO=1.
- Segment crossing: base=1023, count=2 -> writes at a2=1023 and a2=1024. Then `mem` readback at addresses 1023 and 1024 matches.
- Range error: base=6143, count=2 -> error=1, no `we` pulse, startIO=0. A subsequent valid start clears error.
- Zero count and mid-transfer reset:
  - count=0 -> done pulses in E+1 with no writes.
  - rst after 2 of 4 bytes -> outputs go to reset values. A new 4-byte load then writes the new word only.
- Stall and verify:
  - in_valid toggled 1/0 every cycle -> the same words as the simple load, with in_ready never high in WRITE.
  - With MEM_LOADER_VERIFY_EN and rd2 forced to 0xDEADBEEF -> error=1 after the first word.
